// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard detection and stall/flush control for a 5-stage pipeline
//   that resolves branches and jumps in ID.
//
//   Detects four hazard kinds against the instruction in ID:
//     - load-use             (EX load feeds an ALU/store operand)  : 1 stall
//     - ALU-to-branch        (EX ALU result feeds a branch/jump)   : 1 stall
//     - load-to-branch (EX)  (EX load feeds a branch/jump)         : 2 stalls
//     - load-to-branch (MEM) (MEM load feeds a branch/jump)        : 1 stall
//   Stalls are asserted in the same cycle the hazard is seen. A two-cycle
//   hazard parks the FSM in HOLD for the second stall cycle. Register 0 never
//   matches. MemStall freezes everything and drives all controls inactive.
//
//   Build option:
//     HAZARD_STATS_EN  adds saturating 32-bit StallCount / FlushCount outputs.
//
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     IF_ID_Rs, IF_ID_Rt       ID-stage source registers
//     UsesRt                   ID instruction reads Rt as ALU/store operand
//     ID_EX_MemRead/RegWrite/Rd  EX-stage load flag, write enable, destination
//     EX_MEM_MemRead/Rd        MEM-stage load flag, destination
//     PCWriteCond, Jump        ID branch type / jump type (nonzero = active)
//     BranchTaken              ID compare result (meaningful with PCWriteCond)
//     MemStall                 external memory wait request
//     PCWrite, IF_ID_Write     PC and IF/ID register write enables
//     ID_EX_Bubble             insert a bubble into ID/EX
//     IF_ID_Flush              squash the instruction in IF/ID
//     StallCount, FlushCount   (HAZARD_STATS_EN only) event counters
// -----------------------------------------------------------------------------
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        UsesRt,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_RegWrite,
  input  logic [4:0]  ID_EX_Rd,
  input  logic        EX_MEM_MemRead,
  input  logic [4:0]  EX_MEM_Rd,
  input  logic [3:0]  PCWriteCond,
  input  logic [1:0]  Jump,
  input  logic        BranchTaken,
  input  logic        MemStall,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Bubble,
  output logic        IF_ID_Flush
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCount,
  output logic [31:0] FlushCount
`endif
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0] state;
  logic [0:0] state_next;

  // Operand-match terms; a zero destination never matches.
  logic ex_rd_nz;
  logic mem_rd_nz;
  logic cond_act;
  logic jump_act;
  logic br;
  logic ma_ex;
  logic mb_ex;
  logic mb_mem;

  always_comb begin
    ex_rd_nz  = (ID_EX_Rd  != REG_W'(0));
    mem_rd_nz = (EX_MEM_Rd != REG_W'(0));
    cond_act  = (PCWriteCond != 4'(0));
    jump_act  = (Jump != 2'(0));
    br        = cond_act || jump_act;

    ma_ex  = ex_rd_nz &&
             ((ID_EX_Rd == IF_ID_Rs) || (UsesRt && (ID_EX_Rd == IF_ID_Rt)));
    mb_ex  = ex_rd_nz &&
             ((ID_EX_Rd == IF_ID_Rs) || (cond_act && (ID_EX_Rd == IF_ID_Rt)));
    mb_mem = mem_rd_nz &&
             ((EX_MEM_Rd == IF_ID_Rs) || (cond_act && (EX_MEM_Rd == IF_ID_Rt)));
  end

  // Hazard classification by required stall length.
  logic haz_load_use;
  logic haz_alu_br;
  logic haz_ld_br_ex;
  logic haz_ld_br_mem;
  logic haz_one;
  logic haz_two;

  always_comb begin
    haz_load_use  = ID_EX_MemRead && ma_ex && !br;
    haz_alu_br    = br && ID_EX_RegWrite && !ID_EX_MemRead && mb_ex;
    haz_ld_br_ex  = br && ID_EX_MemRead && mb_ex;
    haz_ld_br_mem = br && EX_MEM_MemRead && mb_mem;
    haz_one       = haz_load_use || haz_alu_br || haz_ld_br_mem;
    haz_two       = haz_ld_br_ex;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Mealy control outputs.
  logic stall;
  logic flush;

  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    flush        = 1'b0;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;

    case (state)
      IDLE: begin
        stall = haz_one || haz_two;
        if (haz_two) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        stall      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A taken branch/jump only redirects once no hazard holds it back.
    flush = !stall && br && (BranchTaken || jump_act);

    if (MemStall) begin
      // Memory wait freezes the FSM and idles every control.
      state_next   = state;
      stall        = 1'b0;
      flush        = 1'b0;
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
    end else if (stall) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (flush) begin
      IF_ID_Flush  = 1'b1;
    end

    // Reset forces the pass-through controls regardless of inputs.
    if (rst) begin
      stall        = 1'b0;
      flush        = 1'b0;
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Bubble = 1'b0;
      IF_ID_Flush  = 1'b0;
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating event counters; stall/flush are already gated by MemStall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= CNT_W'(0);
      FlushCount <= CNT_W'(0);
    end else begin
      if (stall && (StallCount != {CNT_W{1'b1}})) begin
        StallCount <= StallCount + CNT_W'(1);
      end
      if (flush && (FlushCount != {CNT_W{1'b1}})) begin
        FlushCount <= FlushCount + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl. Each stimulus cycle pushes its expected
//   control vector {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush} into a
//   scoreboard queue; a monitor pops and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic        UsesRt;
  logic        ID_EX_MemRead;
  logic        ID_EX_RegWrite;
  logic [4:0]  ID_EX_Rd;
  logic        EX_MEM_MemRead;
  logic [4:0]  EX_MEM_Rd;
  logic [3:0]  PCWriteCond;
  logic [1:0]  Jump;
  logic        BranchTaken;
  logic        MemStall;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        ID_EX_Bubble;
  logic        IF_ID_Flush;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCount;
  logic [31:0] FlushCount;
`endif

  hazard_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .IF_ID_Rs       (IF_ID_Rs),
    .IF_ID_Rt       (IF_ID_Rt),
    .UsesRt         (UsesRt),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_RegWrite (ID_EX_RegWrite),
    .ID_EX_Rd       (ID_EX_Rd),
    .EX_MEM_MemRead (EX_MEM_MemRead),
    .EX_MEM_Rd      (EX_MEM_Rd),
    .PCWriteCond    (PCWriteCond),
    .Jump           (Jump),
    .BranchTaken    (BranchTaken),
    .MemStall       (MemStall),
    .PCWrite        (PCWrite),
    .IF_ID_Write    (IF_ID_Write),
    .ID_EX_Bubble   (ID_EX_Bubble),
    .IF_ID_Flush    (IF_ID_Flush)
`ifdef HAZARD_STATS_EN
    ,
    .StallCount     (StallCount),
    .FlushCount     (FlushCount)
`endif
  );

  always #5 clk = ~clk;

  // Expected vectors {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush}.
  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0010;
  localparam logic [3:0] FLUSH = 4'b1101;
  localparam logic [3:0] MWAIT = 4'b0000;

  typedef struct {
    string       name;
    logic [3:0]  bits;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_sc     = 0;
  logic [31:0] m_fc     = 0;

  // Monitor: one scoreboard entry is consumed per cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t       e;
      logic [3:0] act;
      e   = sb.pop_front();
      act = {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush};
      checks++;
      if (act !== e.bits) begin
        failures++;
        $display("FAIL %s: ctrl actual=%b required=%b", e.name, act, e.bits);
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (StallCount !== e.sc || FlushCount !== e.fc) begin
        failures++;
        $display("FAIL %s: counts actual=%0d/%0d required=%0d/%0d",
                 e.name, StallCount, FlushCount, e.sc, e.fc);
      end
`endif
    end
  end

  task automatic clr();
    IF_ID_Rs       = 5'd0;
    IF_ID_Rt       = 5'd0;
    UsesRt         = 1'b0;
    ID_EX_MemRead  = 1'b0;
    ID_EX_RegWrite = 1'b0;
    ID_EX_Rd       = 5'd0;
    EX_MEM_MemRead = 1'b0;
    EX_MEM_Rd      = 5'd0;
    PCWriteCond    = 4'd0;
    Jump           = 2'd0;
    BranchTaken    = 1'b0;
    MemStall       = 1'b0;
  endtask

  // Push the expectation for the cycle now driven, then advance one cycle.
  task automatic cyc(input string nm, input logic [3:0] e);
    exp_t x;
    if (rst) begin
      m_sc = 0;
      m_fc = 0;
    end
    x.name = nm;
    x.bits = e;
    x.sc   = m_sc;
    x.fc   = m_fc;
    sb.push_back(x);
    if (!rst) begin
      if (e == STALL) m_sc++;
      if (e[0])       m_fc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ld_br_ex();
    clr();
    PCWriteCond   = 4'd1;
    ID_EX_MemRead = 1'b1;
    ID_EX_Rd      = 5'd8;
    IF_ID_Rt      = 5'd8;
    IF_ID_Rs      = 5'd3;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset dominates even with a hazard present.
    cyc("reset_idle", NORM);
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd5; IF_ID_Rs = 5'd5;
    cyc("reset_with_hazard", NORM);
    rst = 1'b0;
    clr();
    cyc("idle_normal", NORM);

    // Load-use: exactly one stall.
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd5; IF_ID_Rs = 5'd5;
    cyc("load_use_stall", STALL);
    clr();
    cyc("load_use_after", NORM);

    // Rt only matters for load-use when UsesRt is set.
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd6; IF_ID_Rt = 5'd6; IF_ID_Rs = 5'd1;
    cyc("rt_unused_no_stall", NORM);
    UsesRt = 1'b1;
    cyc("rt_used_stall", STALL);
    clr();
    cyc("rt_used_after", NORM);

    // Register 0 never hazards.
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd0; IF_ID_Rs = 5'd0;
    cyc("r0_no_stall", NORM);

    // Load-to-branch in EX: two stalls, second one held by the FSM alone.
    ld_br_ex();
    cyc("ld_br_ex_stall1", STALL);
    clr();
    cyc("ld_br_ex_stall2_hold", STALL);
    PCWriteCond = 4'd1; BranchTaken = 1'b1;
    cyc("ld_br_ex_flush_after", FLUSH);
    clr();
    cyc("ld_br_ex_normal", NORM);

    // Load-to-branch in MEM: one stall.
    EX_MEM_MemRead = 1'b1; EX_MEM_Rd = 5'd9; IF_ID_Rs = 5'd9; PCWriteCond = 4'd2;
    cyc("ld_br_mem_stall", STALL);
    clr();
    cyc("ld_br_mem_after", NORM);

    // ALU-to-branch with a jump: stall then single-cycle flush.
    Jump = 2'd2; ID_EX_RegWrite = 1'b1; ID_EX_Rd = 5'd31; IF_ID_Rs = 5'd31;
    cyc("alu_br_stall", STALL);
    ID_EX_RegWrite = 1'b0; ID_EX_Rd = 5'd0;
    cyc("alu_br_flush", FLUSH);
    clr();
    cyc("alu_br_after", NORM);

    // Jump without branch type: Rt match is not a hazard, jump flushes.
    Jump = 2'd1; ID_EX_RegWrite = 1'b1; ID_EX_Rd = 5'd7; IF_ID_Rt = 5'd7;
    IF_ID_Rs = 5'd3; UsesRt = 1'b1;
    cyc("jump_rt_no_hazard_flush", FLUSH);
    clr();

    // Branch not taken, and BranchTaken without a branch.
    PCWriteCond = 4'd4;
    cyc("branch_not_taken", NORM);
    PCWriteCond = 4'd0; BranchTaken = 1'b1;
    cyc("taken_without_branch", NORM);
    clr();

    // MemStall in HOLD: state held for 3 cycles, then the last stall.
    ld_br_ex();
    cyc("mstall_enter_hold", STALL);
    clr();
    MemStall = 1'b1;
    cyc("mstall_hold_1", MWAIT);
    cyc("mstall_hold_2", MWAIT);
    cyc("mstall_hold_3", MWAIT);
    MemStall = 1'b0;
    cyc("mstall_resume_stall", STALL);
    cyc("mstall_back_idle", NORM);

    // MemStall in IDLE blocks a two-cycle hazard from entering HOLD.
    ld_br_ex();
    MemStall = 1'b1;
    cyc("mstall_idle_hazard", MWAIT);
    clr();
    cyc("mstall_idle_no_hold", NORM);

    // MemStall suppresses a flush too.
    Jump = 2'd3; MemStall = 1'b1;
    cyc("mstall_blocks_flush", MWAIT);
    clr();

    // Reset in HOLD abandons the remaining stall.
    ld_br_ex();
    cyc("rst_hold_enter", STALL);
    clr();
    rst = 1'b1;
    cyc("rst_hold_reset", NORM);
    rst = 1'b0;
    cyc("rst_hold_abandoned", NORM);

    // Three load-use hazards and two taken branches, then reset.
    for (int i = 0; i < 3; i++) begin
      ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd12; IF_ID_Rs = 5'd12;
      cyc("stats_load_use", STALL);
      clr();
    end
    for (int i = 0; i < 2; i++) begin
      PCWriteCond = 4'd1; BranchTaken = 1'b1;
      cyc("stats_taken", FLUSH);
      clr();
    end
    cyc("stats_idle", NORM);
    rst = 1'b1;
    cyc("stats_reset", NORM);
    rst = 1'b0;
    cyc("stats_after_reset", NORM);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
